// File: rtl/cmd_sequencer.sv
// cmd_sequencer
// Queues {opcode, data} commands in a small FIFO and plays them out one at a
// time to a RemoteComm link, waiting for an acknowledge byte, retrying on a
// negative response or on timeout, and reporting done/fail per command.
//
// Ports
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   push/push_cmd/push_data  enqueue one command (dropped and ovf set if full)
//   abort             flush the queue and return to IDLE (push that cycle lost)
//   resp_rdy/resp     response level + byte from RemoteComm
//   cmd/data          payload presented to RemoteComm, held from SEND to next pop
//   send_cmd          one-cycle send strobe
//   clr_resp_rdy      one-cycle strobe asking RemoteComm to drop resp_rdy
//   full/empty        FIFO status
//   busy              FSM not in IDLE
//   cmd_done/cmd_fail one-cycle result pulses (cycle after the decision)
//   err/ovf           sticky: a command failed / a push hit a full FIFO
//
// Link handshake: send_cmd is a single-cycle strobe with cmd/data stable in the
// same cycle. RemoteComm answers by raising resp_rdy (a level) with resp valid
// while it is high; resp_rdy stays high until this block pulses clr_resp_rdy,
// which RemoteComm samples on the next rising edge to drop resp_rdy. A resp_rdy
// seen in IDLE is a stale answer and is cleared without being interpreted.
module cmd_sequencer #(
  parameter int         DEPTH       = 8,
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter int         MAX_RETRY   = 2,
  parameter logic [7:0] ACK         = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  push_cmd,
  input  logic [15:0] push_data,
  input  logic        abort,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        send_cmd,
  output logic        clr_resp_rdy,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        cmd_done,
  output logic        cmd_fail,
  output logic        err,
  output logic        ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_CLR  = 2'd3
  } state_e;

  // FSM and datapath state
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    resp_q, resp_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [15:0]   data_q, data_d;
  logic          send_q, send_d;
  logic          clr_q, clr_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;

  // FIFO
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   head;
  logic          fifo_full, fifo_empty;
  logic          push_ok, pop, fail_now;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    resp_d   = resp_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    send_d   = 1'b0;
    clr_d    = 1'b0;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    err_d    = err_q;
    ovf_d    = ovf_q;
    pop      = 1'b0;
    fail_now = 1'b0;

    // Outputs are registered, so strobes that must be visible *during* SEND
    // and CLR are raised on the edge that enters those states.
    case (state_q)
      S_IDLE: begin
        // Stale response: clear once; clr_q guards against a second strobe
        // while RemoteComm is still dropping resp_rdy.
        if (resp_rdy && !clr_q) clr_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          cmd_d   = head[23:16];
          data_d  = head[15:0];
          retry_d = '0;
          send_d  = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_rdy) begin
          resp_d  = resp;
          clr_d   = 1'b1;
          state_d = S_CLR;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          fail_now = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CLR: begin
        if (resp_q == ACK) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          fail_now = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared failure decision for NAK and timeout: resend the same payload
    // until the retry budget is spent, then drop the command.
    if (fail_now) begin
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + RW'(1);
        send_d  = 1'b1;
        state_d = S_SEND;
      end else begin
        fail_d  = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end

    push_ok = push && !fifo_full && !abort;
    if (push && fifo_full && !abort) ovf_d = 1'b1;

    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push_ok) - CW'(pop);

    // abort wins over everything above; sticky flags keep their old value.
    if (abort) begin
      state_d  = S_IDLE;
      timer_d  = '0;
      retry_d  = '0;
      send_d   = 1'b0;
      clr_d    = 1'b0;
      done_d   = 1'b0;
      fail_d   = 1'b0;
      err_d    = err_q;
      ovf_d    = ovf_q;
      pop      = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      retry_q  <= '0;
      resp_q   <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      send_q   <= 1'b0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      resp_q   <= resp_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      send_q   <= send_d;
      clr_q    <= clr_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= {push_cmd, push_data};
  end

  assign cmd          = cmd_q;
  assign data         = data_q;
  assign send_cmd     = send_q;
  assign clr_resp_rdy = clr_q;
  assign full         = fifo_full;
  assign empty        = fifo_empty;
  assign busy         = (state_q != S_IDLE);
  assign cmd_done     = done_q;
  assign cmd_fail     = fail_q;
  assign err          = err_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Testbench for cmd_sequencer: clock/reset, a RemoteComm responder model,
// a send monitor with an expected-payload queue, a vector table for single
// command outcomes, and hand sequences for timing, overflow/abort and reset.
module tb_cmd_sequencer;

  localparam int         DEPTH = 4;
  localparam int         TMO   = 16;
  localparam int         MAXR  = 2;
  localparam logic [7:0] ACKV  = 8'hA5;

  logic        clk = 1'b0;
  logic        rst, push, abort, resp_rdy;
  logic [7:0]  push_cmd, resp;
  logic [15:0] push_data;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        send_cmd, clr_resp_rdy, full, empty, busy, cmd_done, cmd_fail, err, ovf;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cmd_sequencer #(
    .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .ACK(ACKV)
  ) dut (
    .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .push_data(push_data),
    .abort(abort), .resp_rdy(resp_rdy), .resp(resp), .cmd(cmd), .data(data),
    .send_cmd(send_cmd), .clr_resp_rdy(clr_resp_rdy), .full(full), .empty(empty),
    .busy(busy), .cmd_done(cmd_done), .cmd_fail(cmd_fail), .err(err), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  int          n_send = 0, n_clr = 0, n_done = 0, n_fail = 0;
  int unsigned send_cyc[$];

  always @(negedge clk) begin
    if (send_cmd === 1'b1) begin
      n_send++;
      send_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_send: got cmd %0h data %0h want no send", cmd, data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("send_payload", {8'h00, cmd, data}, {8'h00, mon_e});
      end
    end
    if (clr_resp_rdy === 1'b1) n_clr++;
    if (cmd_done === 1'b1) n_done++;
    if (cmd_fail === 1'b1) n_fail++;
  end

  // ---------------- RemoteComm responder ----------------
  bit silent    = 1'b1;
  bit stale_req = 1'b0;
  int nack_cnt  = 0;
  int resp_dly  = 2;
  int attempt   = 0;
  int cnt       = 0;

  initial begin
    resp_rdy = 1'b0;
    resp     = 8'h00;
    forever begin
      @(negedge clk);
      if (clr_resp_rdy === 1'b1) resp_rdy = 1'b0;
      if (stale_req) begin
        resp_rdy  = 1'b1;
        resp      = 8'h3C;
        stale_req = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          resp_rdy = 1'b1;
          resp     = (attempt <= nack_cnt) ? 8'hFF : ACKV;
        end
      end
      if (send_cmd === 1'b1 && !silent) begin
        attempt++;
        cnt = resp_dly;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_push(input logic [7:0] c, input logic [15:0] d);
    push      = 1'b1;
    push_cmd  = c;
    push_data = d;
    step();
    push      = 1'b0;
  endtask

  task automatic zero_counts();
    n_send = 0; n_clr = 0; n_done = 0; n_fail = 0;
    send_cyc.delete();
  endtask

  task automatic wait_results(input string name, input int target, input int budget);
    int k = 0;
    while ((n_done + n_fail) < target && k < budget) begin
      step();
      k++;
    end
    total++;
    if ((n_done + n_fail) < target) begin
      bad++;
      $display("FAIL %s_timeout: got %0d results want %0d", name, n_done + n_fail, target);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd"}, {24'h0, cmd}, 32'h0);
    chk({tag, "_data"}, {16'h0, data}, 32'h0);
    chk({tag, "_send"}, {31'h0, send_cmd}, 32'h0);
    chk({tag, "_clr"}, {31'h0, clr_resp_rdy}, 32'h0);
    chk({tag, "_done"}, {31'h0, cmd_done}, 32'h0);
    chk({tag, "_fail"}, {31'h0, cmd_fail}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_err"}, {31'h0, err}, 32'h0);
    chk({tag, "_ovf"}, {31'h0, ovf}, 32'h0);
    chk({tag, "_empty"}, {31'h0, empty}, 32'h1);
    chk({tag, "_full"}, {31'h0, full}, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  c;
    logic [15:0] d;
    bit          sil;
    int          nack;
    int          dly;
    int          e_send;
    int          e_done;
    int          e_fail;
    int          e_clr;
  } vec_t;

  vec_t tbl[6];
  bit   exp_err = 1'b0;

  initial begin
    #200_000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    //             cmd    data     sil  nack dly  sends done fail clr
    tbl[0] = '{8'h05, 16'h0100, 1'b0, 0,   2,   1,    1,   0,   1};
    tbl[1] = '{8'h02, 16'hBEEF, 1'b0, 1,   1,   2,    1,   0,   2};
    tbl[2] = '{8'h08, 16'h1234, 1'b0, 2,   3,   3,    1,   0,   3};
    tbl[3] = '{8'h03, 16'hFFFF, 1'b0, 3,   2,   3,    0,   1,   3};
    tbl[4] = '{8'h07, 16'h0001, 1'b1, 0,   2,   3,    0,   1,   0};
    tbl[5] = '{8'h04, 16'h0000, 1'b0, 0,   5,   1,    1,   0,   1};

    // ---- reset: held with push and abort active, which must be ignored
    rst = 1'b1; abort = 1'b1; push = 1'b1; push_cmd = 8'h06; push_data = 16'h5555;
    step(3);
    chk_reset_outputs("rst");
    rst = 1'b0; abort = 1'b0; push = 1'b0;
    step();
    chk("rst_release_empty", {31'h0, empty}, 32'h1);

    // ---- single command, exact cycle timing
    silent = 1'b0; nack_cnt = 0; resp_dly = 2; attempt = 0;
    zero_counts();
    exp_q.push_back({8'h05, 16'h0100});
    do_push(8'h05, 16'h0100);                     // now cycle n+1
    chk("lat_n1_send", {31'h0, send_cmd}, 32'h0);
    chk("lat_n1_empty", {31'h0, empty}, 32'h0);
    step();                                       // n+2 = SEND
    chk("lat_send", {31'h0, send_cmd}, 32'h1);
    chk("lat_cmd", {24'h0, cmd}, 32'h05);
    chk("lat_data", {16'h0, data}, 32'h0100);
    chk("lat_busy", {31'h0, busy}, 32'h1);
    step();
    chk("lat_send_once", {31'h0, send_cmd}, 32'h0);
    step();                                       // response arrives this cycle
    chk("lat_noclr_yet", {31'h0, clr_resp_rdy}, 32'h0);
    step();                                       // CLR
    chk("lat_clr", {31'h0, clr_resp_rdy}, 32'h1);
    chk("lat_done_early", {31'h0, cmd_done}, 32'h0);
    step();
    chk("lat_done", {31'h0, cmd_done}, 32'h1);
    chk("lat_busy_end", {31'h0, busy}, 32'h0);
    chk("lat_clr_once", {31'h0, clr_resp_rdy}, 32'h0);
    step(2);
    chk("lat_nsend", n_send, 1);
    chk("lat_ndone", n_done, 1);

    // ---- table-driven single-command outcomes
    for (int i = 0; i < 6; i++) begin
      step(2);
      silent = tbl[i].sil; nack_cnt = tbl[i].nack; resp_dly = tbl[i].dly; attempt = 0;
      zero_counts();
      for (int j = 0; j < tbl[i].e_send; j++) exp_q.push_back({tbl[i].c, tbl[i].d});
      do_push(tbl[i].c, tbl[i].d);
      wait_results($sformatf("v%0d", i), 1, 200);
      step(3);
      if (tbl[i].e_fail != 0) exp_err = 1'b1;
      chk($sformatf("v%0d_sends", i), n_send, tbl[i].e_send);
      chk($sformatf("v%0d_done", i), n_done, tbl[i].e_done);
      chk($sformatf("v%0d_fail", i), n_fail, tbl[i].e_fail);
      chk($sformatf("v%0d_clr", i), n_clr, tbl[i].e_clr);
      chk($sformatf("v%0d_busy", i), {31'h0, busy}, 32'h0);
      chk($sformatf("v%0d_empty", i), {31'h0, empty}, 32'h1);
      chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, exp_err});
      chk($sformatf("v%0d_cmd_hold", i), {24'h0, cmd}, {24'h0, tbl[i].c});
    end

    // ---- three queued commands go out in FIFO order
    step(2);
    silent = 1'b0; nack_cnt = 0; resp_dly = 2; attempt = 0;
    zero_counts();
    exp_q.push_back({8'h02, 16'h0011});
    exp_q.push_back({8'h03, 16'h0022});
    exp_q.push_back({8'h04, 16'h0033});
    do_push(8'h02, 16'h0011);
    do_push(8'h03, 16'h0022);
    do_push(8'h04, 16'h0033);
    wait_results("fifo3", 3, 300);
    step(3);
    chk("fifo3_sends", n_send, 3);
    chk("fifo3_done", n_done, 3);
    chk("fifo3_fail", n_fail, 0);
    chk("fifo3_empty", {31'h0, empty}, 32'h1);
    chk("fifo3_qleft", exp_q.size(), 0);

    // ---- timeout spacing with a silent link
    step(2);
    silent = 1'b1; attempt = 0;
    zero_counts();
    repeat (3) exp_q.push_back({8'h06, 16'h0A0A});
    do_push(8'h06, 16'h0A0A);
    wait_results("tmo", 1, 200);
    step(3);
    exp_err = 1'b1;
    chk("tmo_sends", n_send, 3);
    chk("tmo_gap1", (send_cyc.size() >= 2) ? send_cyc[1] - send_cyc[0] : 0, TMO + 1);
    chk("tmo_gap2", (send_cyc.size() >= 3) ? send_cyc[2] - send_cyc[1] : 0, TMO + 1);
    chk("tmo_noclr", n_clr, 0);
    chk("tmo_fail", n_fail, 1);
    chk("tmo_err", {31'h0, err}, 32'h1);

    // ---- overflow while WAIT stalls, then abort
    step(2);
    silent = 1'b1; attempt = 0;
    zero_counts();
    exp_q.push_back({8'h02, 16'hAAAA});
    do_push(8'h02, 16'hAAAA);
    step(3);
    chk("ovf_in_wait", {31'h0, busy}, 32'h1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      push = 1'b1; push_cmd = 8'h03; push_data = 16'(i);
      step();
    end
    push = 1'b0;
    chk("ovf_full", {31'h0, full}, 32'h1);
    chk("ovf_flag", {31'h0, ovf}, 32'h1);
    abort = 1'b1; push = 1'b1; push_cmd = 8'h08; push_data = 16'hDEAD;
    step();
    abort = 1'b0; push = 1'b0;
    chk("abort_empty", {31'h0, empty}, 32'h1);
    chk("abort_full", {31'h0, full}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_ovf_kept", {31'h0, ovf}, 32'h1);
    chk("abort_err_kept", {31'h0, err}, {31'h0, exp_err});
    step(25);
    chk("abort_nofail", n_fail, 0);
    chk("abort_nodone", n_done, 0);
    chk("abort_sends", n_send, 1);
    chk("abort_still_empty", {31'h0, empty}, 32'h1);

    // ---- reset mid-WAIT, then a stale response in IDLE
    silent = 1'b1; attempt = 0;
    zero_counts();
    exp_q.push_back({8'h07, 16'h7777});
    do_push(8'h07, 16'h7777);
    step(3);
    chk("rstw_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    step();
    chk_reset_outputs("rstw");
    rst = 1'b0;
    exp_err = 1'b0;
    zero_counts();
    stale_req = 1'b1;
    step(6);
    chk("stale_clr", n_clr, 1);
    chk("stale_send", n_send, 0);
    chk("stale_done", n_done, 0);
    chk("stale_busy", {31'h0, busy}, 32'h0);
    step(20);
    chk("rstw_nofail", n_fail, 0);
    chk("rstw_err", {31'h0, err}, 32'h0);
    chk("rstw_qleft", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1_000_000, clk cycles allowed per response.
REQ-003 SHALL have parameter MAX_RETRY, default 2, resends after first failed attempt.
REQ-004 SHALL have parameter ACK, default 8'hA5, positive acknowledge value.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 push  input  1  enqueue {push_cmd, push_data} this cycle.
REQ-008 push_cmd  input  8  command opcode to enqueue (02..08).
REQ-009 push_data  input  16  data word to enqueue.
REQ-010 abort  input  1  flush queue and return to IDLE.
REQ-011 resp_rdy  input  1  RemoteComm response valid (level).
REQ-012 resp  input  8  RemoteComm response byte.
REQ-013 cmd  output  8  opcode presented to RemoteComm.
REQ-014 data  output  16  data presented to RemoteComm.
REQ-015 send_cmd  output  1  one-cycle send strobe to RemoteComm.
REQ-016 clr_resp_rdy  output  1  one-cycle strobe knocking down resp_rdy.
REQ-017 full  output  1  FIFO holds DEPTH entries.
REQ-018 empty  output  1  FIFO holds 0 entries.
REQ-019 busy  output  1  state != IDLE.
REQ-020 cmd_done  output  1  one-cycle pulse: current command ACKed.
REQ-021 cmd_fail  output  1  one-cycle pulse: retries exhausted.
REQ-022 err  output  1  sticky: any cmd_fail since reset.
REQ-023 ovf  output  1  sticky: push attempted while full.

Function
REQ-024 SHALL store {cmd,data} in a DEPTH-entry FIFO with wrap-around pointers and log2(DEPTH)+1-bit count.
REQ-025 push while full SHALL be dropped and set ovf; push and pop in same cycle SHALL both occur, count unchanged.
REQ-026 FSM states SHALL be IDLE, SEND, WAIT, CLR.
REQ-027 IDLE, !empty, !abort: pop head into cur_cmd/cur_data, retry:=0, next SEND; entry visible on cmd/data from SEND onward.
REQ-028 IDLE with resp_rdy high: assert clr_resp_rdy one cycle (stale-response cleanup).
REQ-029 SEND: send_cmd=1 for exactly this cycle, timer:=0, next WAIT.
REQ-030 WAIT: resp_rdy=1 -> latch resp, next CLR; else timer increments.
REQ-031 WAIT: timer==TIMEOUT_CYC-1 with resp_rdy=0 -> failure decision (REQ-033) without clr_resp_rdy.
REQ-032 CLR: clr_resp_rdy=1 this cycle; latched resp==ACK -> cmd_done=1, next IDLE; else failure decision.
REQ-033 Failure decision: retry<MAX_RETRY -> retry+1, next SEND (same cur_cmd/cur_data); else cmd_fail=1, err:=1, next IDLE (command dropped).
REQ-034 Responses arriving after timeout SHALL be accepted by the next WAIT of a retry; no tagging.
REQ-035 abort SHALL have priority over all transitions: FIFO emptied, state:=IDLE, timer/retry cleared, no cmd_done/cmd_fail; err/ovf unchanged.
REQ-036 Push in the abort cycle SHALL be discarded.
REQ-037 cmd, data SHALL hold value from SEND until next pop.
REQ-038 Minimum latency push -> send_cmd: 2 cycles (push@n, pop@n+1, send_cmd@n+2).

Reset
REQ-039 rst SHALL clear FIFO (empty=1, full=0), state:=IDLE, timer/retry:=0.
REQ-040 rst SHALL drive cmd=0, data=0, send_cmd=0, clr_resp_rdy=0, cmd_done=0, cmd_fail=0, busy=0, err=0, ovf=0.
REQ-041 rst SHALL override abort and push; mid-transaction rst drops in-flight command without pulses.

Verification
REQ-042 Push {05,0x0100}, resp_rdy with A5 two cycles after send_cmd -> one send_cmd, cmd=05, data=0100, clr_resp_rdy, cmd_done, busy=0.
REQ-043 Push 3 commands; responses A5 -> three sends in FIFO order, three cmd_done, empty=1.
REQ-044 MAX_RETRY=2, resp=FF always -> three send_cmd same payload, one cmd_fail, err=1, next entry then sent.
REQ-045 TIMEOUT_CYC=16, no resp -> send_cmd spaced 17 cycles, 3 sends, cmd_fail, no clr_resp_rdy.
REQ-046 Push DEPTH+1 entries while WAIT stalls -> full=1, ovf=1, last entry dropped; then abort -> empty=1, busy=0 next cycle.
REQ-047 rst asserted in WAIT -> all outputs at reset values next cycle; later resp_rdy in IDLE -> clr_resp_rdy only.
